// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants for the FFT datapath and its post-processing blocks.
//   FFT_FRAME_LEN : FFT points per frame (power of two)
//   FFT_BIN_W     : bin-index width, log2(FFT_FRAME_LEN)
//   FFT_DATA_W    : width of the signed real/imag parts of one bin
//   FFT_SQ_W      : width of one unsigned square (re*re or im*im)
//   FFT_PWR_W     : width of the unsigned power re^2+im^2
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_FRAME_LEN = 16;
  localparam int FFT_BIN_W     = 4;
  localparam int FFT_DATA_W    = 16;
  localparam int FFT_PROD_W    = 2 * FFT_DATA_W;
  // (-32768)^2 = 2^30 is the largest square, so 31 bits hold it unsigned.
  localparam int FFT_SQ_W      = 31;
  // Two maximal squares sum to exactly 2^31, which still fits in 32 bits.
  localparam int FFT_PWR_W     = 32;

  typedef logic [FFT_PWR_W-1:0] fft_pwr_t;

  // Exact square of a signed sample. Operands are sign-extended to the full
  // product width first so the multiply is done at 32 bits; the top bit of
  // the result is always 0.
  function automatic logic [FFT_PROD_W-1:0] fft_square(
    input logic signed [FFT_DATA_W-1:0] x
  );
    logic signed [FFT_PROD_W-1:0] w_x;
    w_x = FFT_PROD_W'(x);
    return FFT_PROD_W'(w_x * w_x);
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// -----------------------------------------------------------------------------
// fft_mag_sq
// Two-stage power pipeline: S1 registers re*re and im*im, S2 registers their
// 32-bit sum. Both stages advance only while i_en is high.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_en            : pipeline advance enable (downstream ready)
//   i_valid, i_bin  : sample valid and bin index entering S1
//   i_real, i_imag  : signed bin value
//   o_cap           : S2 is capturing a valid sample on this edge
//   o_cap_bin/pwr   : bin/power that S2 is capturing on this edge
//   o_valid         : S2 valid
//   o_bin, o_pwr    : S2 bin index and power
// -----------------------------------------------------------------------------
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int BIN_W = FFT_BIN_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_en,
  input  logic                         i_valid,
  input  logic [BIN_W-1:0]             i_bin,
  input  logic signed [FFT_DATA_W-1:0] i_real,
  input  logic signed [FFT_DATA_W-1:0] i_imag,
  output logic                         o_cap,
  output logic [BIN_W-1:0]             o_cap_bin,
  output logic [FFT_PWR_W-1:0]         o_cap_pwr,
  output logic                         o_valid,
  output logic [BIN_W-1:0]             o_bin,
  output logic [FFT_PWR_W-1:0]         o_pwr
);

  logic                 r_s1_valid;
  logic [BIN_W-1:0]     r_s1_bin;
  logic [FFT_SQ_W-1:0]  r_re_sq;
  logic [FFT_SQ_W-1:0]  r_im_sq;

  logic                 r_s2_valid;
  logic [BIN_W-1:0]     r_s2_bin;
  logic [FFT_PWR_W-1:0] r_s2_pwr;

  logic [FFT_PWR_W-1:0] w_sum;

  // Zero-extend both squares so the carry out of bit 30 lands in bit 31.
  assign w_sum     = {1'b0, r_re_sq} + {1'b0, r_im_sq};
  assign o_cap     = i_en & r_s1_valid;
  assign o_cap_bin = r_s1_bin;
  assign o_cap_pwr = w_sum;

  // S1: square both parts of the incoming sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_bin   <= {BIN_W{1'b0}};
      r_re_sq    <= {FFT_SQ_W{1'b0}};
      r_im_sq    <= {FFT_SQ_W{1'b0}};
    end else if (i_en) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_bin <= i_bin;
        r_re_sq  <= FFT_SQ_W'(fft_square(i_real));
        r_im_sq  <= FFT_SQ_W'(fft_square(i_imag));
      end
    end
  end

  // S2: register the power; data holds through bubbles, only the valid drops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_bin   <= {BIN_W{1'b0}};
      r_s2_pwr   <= {FFT_PWR_W{1'b0}};
    end else if (i_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_bin <= r_s1_bin;
        r_s2_pwr <= w_sum;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_bin   = r_s2_bin;
  assign o_pwr   = r_s2_pwr;

endmodule

// File: rtl/fft_peak_detect.sv
// -----------------------------------------------------------------------------
// fft_peak_detect
// Computes per-bin power of FFT output samples and reports, once per frame,
// the bin with the largest power (ties resolve to the lower bin index).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_push               : upstream sample valid
//   in_real, in_imag      : signed bin value
//   in_stall              : upstream must hold (mirrors out_stall)
//   out_push_F            : per-bin power valid
//   out_bin_F, out_pwr_F  : bin index and power re^2+im^2
//   out_stall             : downstream not ready; freezes the whole block
//   peak_valid_F          : frame peak available (with the last bin's output)
//   peak_bin_F/peak_pwr_F : peak of the most recently completed frame
// -----------------------------------------------------------------------------
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int BIN_W     = FFT_BIN_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_push,
  input  logic signed [FFT_DATA_W-1:0] in_real,
  input  logic signed [FFT_DATA_W-1:0] in_imag,
  output logic                         in_stall,
  output logic                         out_push_F,
  output logic [BIN_W-1:0]             out_bin_F,
  output logic [FFT_PWR_W-1:0]         out_pwr_F,
  input  logic                         out_stall,
  output logic                         peak_valid_F,
  output logic [BIN_W-1:0]             peak_bin_F,
  output logic [FFT_PWR_W-1:0]         peak_pwr_F
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  logic                 w_en;
  logic                 w_accept;
  logic                 w_cap;
  logic [BIN_W-1:0]     w_cap_bin;
  logic [FFT_PWR_W-1:0] w_cap_pwr;
  logic                 w_take;
  logic                 w_last;
  logic [BIN_W-1:0]     w_new_max_bin;
  logic [FFT_PWR_W-1:0] w_new_max_pwr;

  logic [BIN_W-1:0]     r_bin;
  logic [BIN_W-1:0]     r_max_bin;
  logic [FFT_PWR_W-1:0] r_max_pwr;
  logic                 r_peak_valid;
  logic [BIN_W-1:0]     r_peak_bin;
  logic [FFT_PWR_W-1:0] r_peak_pwr;

  // No skid buffer: backpressure passes straight through.
  assign in_stall = out_stall;
  assign w_en     = ~out_stall;
  assign w_accept = in_push & w_en;

  fft_mag_sq #(
    .BIN_W (BIN_W)
  ) u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_en),
    .i_valid   (w_accept),
    .i_bin     (r_bin),
    .i_real    (in_real),
    .i_imag    (in_imag),
    .o_cap     (w_cap),
    .o_cap_bin (w_cap_bin),
    .o_cap_pwr (w_cap_pwr),
    .o_valid   (out_push_F),
    .o_bin     (out_bin_F),
    .o_pwr     (out_pwr_F)
  );

  // Bin counter: advances per accepted sample and wraps at the frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin <= {BIN_W{1'b0}};
    end else if (w_accept) begin
      if (r_bin == LAST_BIN) begin
        r_bin <= {BIN_W{1'b0}};
      end else begin
        r_bin <= r_bin + {{(BIN_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Running-max update decision, evaluated against the sample S2 is capturing
  // so the frame peak can be published in the same cycle as the last bin.
  always_comb begin
    w_take = 1'b0;
    w_last = 1'b0;
    if (w_cap) begin
      w_last = (w_cap_bin == LAST_BIN);
      if (w_cap_bin == {BIN_W{1'b0}}) begin
        // First bin of a frame always restarts the search.
        w_take = 1'b1;
      end else if (w_cap_pwr > r_max_pwr) begin
        w_take = 1'b1;
      end else begin
        w_take = 1'b0;
      end
    end else begin
      w_take = 1'b0;
      w_last = 1'b0;
    end
    w_new_max_bin = w_take ? w_cap_bin : r_max_bin;
    w_new_max_pwr = w_take ? w_cap_pwr : r_max_pwr;
  end

  // Peak tracker: running max plus the published peak of the last full frame.
  // The peak pulse is frozen by a stall just like out_push_F it accompanies.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max_bin    <= {BIN_W{1'b0}};
      r_max_pwr    <= {FFT_PWR_W{1'b0}};
      r_peak_valid <= 1'b0;
      r_peak_bin   <= {BIN_W{1'b0}};
      r_peak_pwr   <= {FFT_PWR_W{1'b0}};
    end else if (w_en) begin
      r_max_bin    <= w_new_max_bin;
      r_max_pwr    <= w_new_max_pwr;
      r_peak_valid <= w_last;
      if (w_last) begin
        r_peak_bin <= w_new_max_bin;
        r_peak_pwr <= w_new_max_pwr;
      end
    end
  end

  assign peak_valid_F = r_peak_valid;
  assign peak_bin_F   = r_peak_bin;
  assign peak_pwr_F   = r_peak_pwr;

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_push;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               in_stall;
  logic               out_push_F;
  logic [3:0]         out_bin_F;
  logic [31:0]        out_pwr_F;
  logic               out_stall;
  logic               peak_valid_F;
  logic [3:0]         peak_bin_F;
  logic [31:0]        peak_pwr_F;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [15:0] re_v [16];
  logic signed [15:0] im_v [16];
  logic [31:0]        pw_v [16];
  int peaks;
  int span;

  always #5 clk = ~clk;

  fft_peak_detect #(
    .FRAME_LEN (16),
    .BIN_W     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_push      (in_push),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .in_stall     (in_stall),
    .out_push_F   (out_push_F),
    .out_bin_F    (out_bin_F),
    .out_pwr_F    (out_pwr_F),
    .out_stall    (out_stall),
    .peak_valid_F (peak_valid_F),
    .peak_bin_F   (peak_bin_F),
    .peak_pwr_F   (peak_pwr_F)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected power of each table entry, from the sample values themselves.
  task automatic calc_pw();
    for (int i = 0; i < 16; i++) begin
      longint a;
      longint b;
      longint s;
      a = re_v[i];
      b = im_v[i];
      s = a * a + b * b;
      pw_v[i] = s[31:0];
    end
  endtask

  // Streams n samples from the tables (bin = index mod 16), with an optional
  // bubble cycle and stall window, checking every output against a queue.
  task automatic run_frames(input int n, input int gap_at, input int st_at, input int st_len,
                            input logic [3:0] pk_bin, input logic [31:0] pk_pwr,
                            output int n_peaks, output int pk_span);
    int idx;
    int c;
    int first_pk;
    int last_pk;
    logic stall;
    logic [3:0] qb[$];
    logic [31:0] qp[$];
    logic [3:0] eb;
    logic [31:0] ep;
    logic p_push;
    logic p_pv;
    logic [3:0] p_bin;
    logic [31:0] p_pwr;
    idx = 0;
    c = 0;
    first_pk = 0;
    last_pk = 0;
    n_peaks = 0;
    while (((idx < n) || (qb.size() > 0)) && (c < 200)) begin
      stall = (c >= st_at) && (c < st_at + st_len);
      out_stall = stall;
      in_push = (idx < n) && (c != gap_at);
      in_real = re_v[idx % 16];
      in_imag = im_v[idx % 16];
      #1;
      check("in_stall", 32'(in_stall), 32'(stall));
      if (in_push && !stall) begin
        qb.push_back(4'(idx % 16));
        qp.push_back(pw_v[idx % 16]);
        idx++;
      end
      p_push = out_push_F;
      p_pv = peak_valid_F;
      p_bin = out_bin_F;
      p_pwr = out_pwr_F;
      @(posedge clk);
      #1;
      if (stall) begin
        check("frz_push", 32'(out_push_F), 32'(p_push));
        check("frz_bin", 32'(out_bin_F), 32'(p_bin));
        check("frz_pwr", out_pwr_F, p_pwr);
        check("frz_pv", 32'(peak_valid_F), 32'(p_pv));
      end else if (out_push_F) begin
        if (qb.size() == 0) begin
          check("extra_out", 32'(out_push_F), 32'd0);
        end else begin
          eb = qb.pop_front();
          ep = qp.pop_front();
          check("out_bin", 32'(out_bin_F), 32'(eb));
          check("out_pwr", out_pwr_F, ep);
          check("peak_valid", 32'(peak_valid_F), 32'(eb == 4'd15));
          if (eb == 4'd15) begin
            check("peak_bin", 32'(peak_bin_F), 32'(pk_bin));
            check("peak_pwr", peak_pwr_F, pk_pwr);
          end
        end
      end else begin
        check("peak_idle", 32'(peak_valid_F), 32'd0);
      end
      if (peak_valid_F && !stall) begin
        if (n_peaks == 0) first_pk = c;
        last_pk = c;
        n_peaks++;
      end
      c++;
    end
    check("run_budget", 32'(c < 200), 32'd1);
    in_push = 1'b0;
    out_stall = 1'b0;
    pk_span = last_pk - first_pk;
  endtask

  initial begin
    reset = 1'b1;
    in_push = 1'b0;
    in_real = 16'sd0;
    in_imag = 16'sd0;
    out_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_push", 32'(out_push_F), 32'd0);
    check("rst_pv", 32'(peak_valid_F), 32'd0);
    check("rst_bin", 32'(out_bin_F), 32'd0);
    check("rst_pwr", out_pwr_F, 32'd0);
    check("rst_pk_bin", 32'(peak_bin_F), 32'd0);
    check("rst_pk_pwr", peak_pwr_F, 32'd0);
    check("rst_in_stall", 32'(in_stall), 32'd0);

    // (3,4): output two cycles after acceptance, bin 0, power 25
    in_push = 1'b1; in_real = 16'sd3; in_imag = 16'sd4;
    tick();
    in_push = 1'b0;
    check("lat1_push", 32'(out_push_F), 32'd0);
    tick();
    check("lat2_push", 32'(out_push_F), 32'd1);
    check("lat2_bin", 32'(out_bin_F), 32'd0);
    check("lat2_pwr", out_pwr_F, 32'd25);
    tick();
    check("lat3_push", 32'(out_push_F), 32'd0);

    // Largest possible power: both parts -32768, bin 1
    in_push = 1'b1; in_real = 16'sh8000; in_imag = 16'sh8000;
    tick();
    in_push = 1'b0;
    tick();
    check("max_push", 32'(out_push_F), 32'd1);
    check("max_bin", 32'(out_bin_F), 32'd1);
    check("max_pwr", out_pwr_F, 32'h8000_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_pwr", out_pwr_F, 32'd0);

    // Frame: bin5=(100,0), bin9=(0,-100) tie at 10000, others (1,1); bubble at cycle 3
    for (int i = 0; i < 16; i++) begin
      re_v[i] = 16'sd1;
      im_v[i] = 16'sd1;
    end
    re_v[5] = 16'sd100; im_v[5] = 16'sd0;
    re_v[9] = 16'sd0;   im_v[9] = -16'sd100;
    calc_pw();
    run_frames(16, 3, 1000, 0, 4'd5, 32'd10000, peaks, span);
    check("frameA_peaks", 32'(peaks), 32'd1);

    // Frame with a 3-cycle stall; peak at bin 0 (256) below previous frame's 10000
    for (int i = 0; i < 16; i++) begin
      re_v[i] = 16'(i);
      im_v[i] = 16'(16 - i);
    end
    calc_pw();
    run_frames(16, 1000, 5, 3, 4'd0, 32'd256, peaks, span);
    check("frameB_peaks", 32'(peaks), 32'd1);
    tick(); tick(); tick();
    check("hold_pv", 32'(peak_valid_F), 32'd0);
    check("hold_pk_bin", 32'(peak_bin_F), 32'd0);
    check("hold_pk_pwr", peak_pwr_F, 32'd256);

    // Abort a frame after bin 7; reset wins over in_push and out_stall
    for (int i = 0; i < 8; i++) begin
      in_push = 1'b1; in_real = 16'sd200; in_imag = 16'sd0;
      tick();
    end
    reset = 1'b1; in_push = 1'b1; out_stall = 1'b1;
    tick();
    reset = 1'b0; in_push = 1'b0; out_stall = 1'b0;
    check("abort_push", 32'(out_push_F), 32'd0);
    check("abort_pv", 32'(peak_valid_F), 32'd0);
    check("abort_pk_pwr", peak_pwr_F, 32'd0);
    check("abort_pwr", out_pwr_F, 32'd0);
    for (int i = 0; i < 16; i++) begin
      re_v[i] = 16'(i);
      im_v[i] = 16'sd0;
    end
    re_v[10] = 16'sd0; im_v[10] = 16'sd50;
    calc_pw();
    run_frames(16, 1000, 1000, 0, 4'd10, 32'd2500, peaks, span);
    check("frameC_peaks", 32'(peaks), 32'd1);

    // Two back-to-back all-zero frames
    for (int i = 0; i < 16; i++) begin
      re_v[i] = 16'sd0;
      im_v[i] = 16'sd0;
    end
    calc_pw();
    run_frames(32, 1000, 1000, 0, 4'd0, 32'd0, peaks, span);
    check("frameD_peaks", 32'(peaks), 32'd2);
    check("frameD_span", 32'(span), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
